// File: rtl/gnn_sched_pkg.sv
// rtl/gnn_sched_pkg.sv - constants, FSM states and assignment record shared by the S1 and S2 scheduler stages
package gnn_sched_pkg;

  localparam int ALL_FEATURE = 3703;
  localparam int ALL_CORE    = 64;
  localparam int CHUNK_LOG2  = 5;
  localparam int ID_W        = 12;
  localparam int CHUNK       = 1 << CHUNK_LOG2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PLAN,
    ST_ISSUE,
    ST_WAIT,
    ST_UPDATE
  } sched_state_t;

  typedef struct packed {
    logic [5:0]      core;
    logic [ID_W-1:0] base;
    logic [5:0]      len;
    logic            last;
  } asg_t;

  // A zero tail means the feature count ends on a chunk boundary, so the chunk is full.
  function automatic logic [5:0] chunk_len(input logic last, input logic [4:0] tail);
    return (last && (tail != 5'd0)) ? {1'b0, tail} : 6'(CHUNK);
  endfunction

endpackage

// File: rtl/s1_round_planner.sv
// rtl/s1_round_planner.sv - combinational round sizing: remaining features, cores used and tail chunk length
module s1_round_planner
  import gnn_sched_pkg::*;
#(
  parameter int FEATURES = ALL_FEATURE,
  parameter int CORES    = ALL_CORE
) (
  input  logic [ID_W-1:0] cur_id,
  output logic [ID_W:0]   rem,
  output logic [6:0]      n_core,
  output logic [4:0]      tail_len
);

  localparam logic [ID_W:0] FEAT_W = (ID_W+1)'(FEATURES);
  localparam logic [ID_W:0] CAP_W  = (ID_W+1)'(CORES);

  logic [ID_W:0] chunks;

  // Round up before shifting so a partial final chunk still gets a core; tail only matters on the node's final round
  always_comb begin
    rem      = FEAT_W - {1'b0, cur_id};
    chunks   = (rem + (ID_W+1)'(CHUNK - 1)) >> CHUNK_LOG2;
    n_core   = (chunks >= CAP_W) ? 7'(CORES) : chunks[6:0];
    tail_len = (chunks <= CAP_W) ? rem[4:0] : 5'd0;
  end

endmodule

// File: rtl/s1_feature_scheduler.sv
// rtl/s1_feature_scheduler.sv - S1 chunk scheduler; optional stall counter under S1_STALL_CNT_EN
module s1_feature_scheduler #(
  parameter int ALL_FEATURE = gnn_sched_pkg::ALL_FEATURE,
  parameter int ALL_CORE    = gnn_sched_pkg::ALL_CORE
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           asg_valid,
  input  logic                           asg_ready,
  output logic [5:0]                     asg_core,
  output logic [gnn_sched_pkg::ID_W-1:0] asg_base,
  output logic [5:0]                     asg_len,
  output logic                           asg_last,
  input  logic                           round_done,
  output logic [gnn_sched_pkg::ID_W-1:0] last_ID,
  output logic                           last_valid,
  output logic                           busy,
  output logic                           node_done
`ifdef S1_STALL_CNT_EN
  ,
  output logic [15:0]                    stall_cycles
`endif
);

  import gnn_sched_pkg::*;

  localparam logic [ID_W-1:0] FEAT_ID = ID_W'(ALL_FEATURE);

  sched_state_t    state;
  logic [ID_W-1:0] cur_id;
  logic [6:0]      n_core_q;
  logic [4:0]      tail_q;
  asg_t            asg_q;

  logic [ID_W:0]   plan_rem;
  logic [6:0]      plan_n_core;
  logic [4:0]      plan_tail;
  logic [6:0]      k_nx;
  logic            nx_last;
  logic [ID_W:0]   round_span;
  logic [ID_W-1:0] next_id;

  s1_round_planner #(
    .FEATURES (ALL_FEATURE),
    .CORES    (ALL_CORE)
  ) u_planner (
    .cur_id   (cur_id),
    .rem      (plan_rem),
    .n_core   (plan_n_core),
    .tail_len (plan_tail)
  );

  // Next-chunk index and end-of-round cursor; cur_id is unchanged since PLAN so plan_rem is still valid in UPDATE
  always_comb begin
    k_nx       = {1'b0, asg_q.core} + 7'd1;
    nx_last    = (k_nx == (n_core_q - 7'd1));
    round_span = (ID_W+1)'(n_core_q) << CHUNK_LOG2;
    next_id    = (plan_rem <= round_span) ? FEAT_ID : (cur_id + round_span[ID_W-1:0]);
  end

  // Main FSM with registered assignment payload and status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cur_id     <= '0;
      n_core_q   <= '0;
      tail_q     <= '0;
      asg_q      <= '0;
      asg_valid  <= 1'b0;
      last_ID    <= '0;
      last_valid <= 1'b0;
      node_done  <= 1'b0;
    end else begin
      last_valid <= 1'b0;
      node_done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            cur_id  <= '0;
            last_ID <= '0;
            state   <= ST_PLAN;
          end
        end
        ST_PLAN: begin
          n_core_q   <= plan_n_core;
          tail_q     <= plan_tail;
          asg_q.core <= 6'd0;
          asg_q.base <= cur_id;
          asg_q.last <= (plan_n_core == 7'd1);
          asg_q.len  <= chunk_len(plan_n_core == 7'd1, plan_tail);
          asg_valid  <= 1'b1;
          state      <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (asg_ready) begin
            asg_q.core <= k_nx[5:0];
            if (asg_q.last) begin
              asg_valid <= 1'b0;
              state     <= ST_WAIT;
            end else begin
              asg_q.base <= asg_q.base + ID_W'(CHUNK);
              asg_q.last <= nx_last;
              asg_q.len  <= chunk_len(nx_last, tail_q);
            end
          end
        end
        ST_WAIT: begin
          if (round_done) begin
            state <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          cur_id     <= next_id;
          last_ID    <= next_id;
          last_valid <= 1'b1;
          if (next_id == FEAT_ID) begin
            node_done <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            state <= ST_PLAN;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef S1_STALL_CNT_EN
  // Saturating count of backpressured ISSUE cycles plus cycles spent waiting on the cores
  always_ff @(posedge clk) begin
    if (rst || ((state == ST_IDLE) && start)) begin
      stall_cycles <= '0;
    end else if ((((state == ST_ISSUE) && !asg_ready) || (state == ST_WAIT)) &&
                 (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

  assign asg_core = asg_q.core;
  assign asg_base = asg_q.base;
  assign asg_len  = asg_q.len;
  assign asg_last = asg_q.last;
  assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_s1_feature_scheduler.sv
// tb/tb_s1_feature_scheduler.sv - scoreboard bench for s1_feature_scheduler at 3703, 2048 and 40 features (S1_STALL_CNT_EN optional)
`timescale 1ns/1ps
module tb_s1_feature_scheduler;
  import gnn_sched_pkg::*;

  localparam int N_DUT = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            start_v      [N_DUT];
  logic            asg_ready_v  [N_DUT];
  logic            round_done_v [N_DUT];
  logic            asg_valid_v  [N_DUT];
  logic [5:0]      asg_core_v   [N_DUT];
  logic [ID_W-1:0] asg_base_v   [N_DUT];
  logic [5:0]      asg_len_v    [N_DUT];
  logic            asg_last_v   [N_DUT];
  logic [ID_W-1:0] last_id_v    [N_DUT];
  logic            last_valid_v [N_DUT];
  logic            busy_v       [N_DUT];
  logic            node_done_v  [N_DUT];
`ifdef S1_STALL_CNT_EN
  logic [15:0]     stall_v      [N_DUT];
`endif

  int   checks   = 0;
  int   failures = 0;
  asg_t exp_q[$];
  int   id_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    localparam int AF = (g == 0) ? 3703 : ((g == 1) ? 2048 : 40);
    s1_feature_scheduler #(
      .ALL_FEATURE (AF),
      .ALL_CORE    (64)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start_v[g]),
      .asg_valid    (asg_valid_v[g]),
      .asg_ready    (asg_ready_v[g]),
      .asg_core     (asg_core_v[g]),
      .asg_base     (asg_base_v[g]),
      .asg_len      (asg_len_v[g]),
      .asg_last     (asg_last_v[g]),
      .round_done   (round_done_v[g]),
      .last_ID      (last_id_v[g]),
      .last_valid   (last_valid_v[g]),
      .busy         (busy_v[g]),
      .node_done    (node_done_v[g])
`ifdef S1_STALL_CNT_EN
      ,
      .stall_cycles (stall_v[g])
`endif
    );
  end

  function automatic int af_of(input int d);
    return (d == 0) ? 3703 : ((d == 1) ? 2048 : 40);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected chunk stream: each chunk is min(32, features left from its base)
  function automatic void build_expected(input int af);
    int cur = 0;
    exp_q.delete();
    id_q.delete();
    while (cur < af) begin
      int rem  = af - cur;
      int n    = (rem + 31) / 32;
      int dsum = 0;
      if (n > 64) n = 64;
      for (int k = 0; k < n; k++) begin
        asg_t a;
        int left = rem - 32 * k;
        a.core = 6'(k);
        a.base = ID_W'(cur + 32 * k);
        a.len  = 6'((left < 32) ? left : 32);
        a.last = (k == n - 1);
        dsum  += int'(a.len);
        exp_q.push_back(a);
      end
      cur += dsum;
      id_q.push_back(cur);
    end
  endfunction

  task automatic run_node(input int d, input bit bp, input int abort_at, input bit noise,
                          input string tag, input int exp_hs, input int exp_core, input int exp_len);
    int   cyc = 0, hs = 0, sum_len = 0, rd_cd = -1, ref_cyc = 0, lat_exp = 2, e = 0;
    bit   armed = 1'b1, held = 1'b0, done = 1'b0, r;
    asg_t got, held_a, want, last_a;
    int   af = af_of(d);
    last_a = '0;
    build_expected(af);
    @(negedge clk);
    start_v[d] = 1'b1;
    while (!done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      start_v[d]      = 1'b0;
      round_done_v[d] = 1'b0;
      got.core = asg_core_v[d];
      got.base = asg_base_v[d];
      got.len  = asg_len_v[d];
      got.last = asg_last_v[d];
      if (last_valid_v[d]) begin
        check({tag, " last_ID queue"}, (id_q.size() != 0), 1);
        if (id_q.size() != 0) begin
          e = id_q.pop_front();
          check({tag, " last_ID"}, last_id_v[d], e);
          check({tag, " node_done"}, node_done_v[d], (e == af));
          check({tag, " busy after update"}, busy_v[d], (e != af));
          if (e == af) done = 1'b1;
        end
      end else begin
        check({tag, " stray node_done"}, node_done_v[d], 0);
      end
      if (rd_cd > 0) begin
        rd_cd--;
        if (rd_cd == 2 && noise) start_v[d] = 1'b1;
        if (rd_cd == 0) begin
          round_done_v[d] = 1'b1;
          ref_cyc = cyc;
          lat_exp = 3;
          armed   = 1'b1;
        end
      end
      if (asg_valid_v[d]) begin
        if (armed) begin
          check({tag, " latency"}, cyc - ref_cyc, lat_exp);
          armed = 1'b0;
        end
        if (held) check({tag, " stall hold"}, got, held_a);
        if (abort_at >= 0 && hs == abort_at) begin
          rst            = 1'b1;
          asg_ready_v[d] = 1'b0;
          @(negedge clk);
          rst = 1'b0;
          check({tag, " abort valid"}, asg_valid_v[d], 0);
          check({tag, " abort busy"}, busy_v[d], 0);
          check({tag, " abort core"}, asg_core_v[d], 0);
          check({tag, " abort last_ID"}, last_id_v[d], 0);
          asg_ready_v[d] = 1'b1;
          exp_q.delete();
          id_q.delete();
          return;
        end
        r = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        asg_ready_v[d] = r;
        if (r) begin
          check({tag, " chunk queue"}, (exp_q.size() != 0), 1);
          want = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
          check({tag, " payload"}, got, want);
          hs++;
          sum_len += int'(got.len);
          held   = 1'b0;
          last_a = got;
          if (got.last) rd_cd = 5;
          if (noise && (got.last || (hs % 9) == 4)) round_done_v[d] = 1'b1;
        end else begin
          held   = 1'b1;
          held_a = got;
        end
      end
    end
    asg_ready_v[d] = 1'b1;
    check({tag, " completed"}, done, 1);
    check({tag, " handshakes"}, hs, exp_hs);
    check({tag, " sum len"}, sum_len, af);
    check({tag, " final core"}, last_a.core, exp_core);
    check({tag, " final len"}, last_a.len, exp_len);
    check({tag, " leftover chunks"}, exp_q.size(), 0);
    check({tag, " leftover ids"}, id_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < N_DUT; i++) begin
      start_v[i]      = 1'b0;
      asg_ready_v[i]  = 1'b1;
      round_done_v[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < N_DUT; i++) begin
      check("reset asg_valid", asg_valid_v[i], 0);
      check("reset asg_core", asg_core_v[i], 0);
      check("reset asg_base", asg_base_v[i], 0);
      check("reset asg_len", asg_len_v[i], 0);
      check("reset asg_last", asg_last_v[i], 0);
      check("reset last_ID", last_id_v[i], 0);
      check("reset last_valid", last_valid_v[i], 0);
      check("reset busy", busy_v[i], 0);
      check("reset node_done", node_done_v[i], 0);
    end
    rst = 1'b0;
    @(negedge clk);

    run_node(0, 1'b0, -1, 1'b0, "af3703", 116, 51, 23);
    run_node(1, 1'b0, -1, 1'b0, "af2048", 64, 63, 32);
    run_node(2, 1'b0, -1, 1'b0, "af40", 2, 1, 8);
    run_node(0, 1'b1, -1, 1'b0, "backpressure", 116, 51, 23);
    run_node(0, 1'b0, 30, 1'b0, "abort", 0, 0, 0);
    run_node(0, 1'b0, -1, 1'b0, "restart", 116, 51, 23);
    run_node(0, 1'b0, -1, 1'b1, "noise", 116, 51, 23);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/s1_feature_scheduler.md
Name: s1_feature_scheduler

Overview:
- Upstream stage of the S2 core-allocation block. Walks one node's feature vector (ALL_FEATURE features) in 32-feature chunks, spread across ALL_CORE cores per round.
- Issues one chunk assignment per handshake.
- Waits for the cores to finish each round, then publishes last_ID, the first feature index not yet processed. S2 consumes last_ID.

Parameters:
- ALL_FEATURE, 3703, total feature count per node.
- ALL_CORE, 64, cores available per round (power of two).
- CHUNK_LOG2, 5, log2 of features per chunk (32).
- ID_W, 12, feature index width; must satisfy 2^ID_W > ALL_FEATURE.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a node. Ignored unless in IDLE.
- asg_valid  out  1  chunk assignment valid.
- asg_ready  in  1  downstream accepts assignment.
- asg_core  out  6  core index, 0..ALL_CORE-1.
- asg_base  out  ID_W  first feature index of the chunk.
- asg_len  out  6  chunk length, 1..32.
- asg_last  out  1  marks the last chunk of the round.
- round_done  in  1  pulse: all cores in the round have finished.
- last_ID  out  ID_W  next unprocessed feature index.
- last_valid  out  1  one-cycle pulse when last_ID updates.
- busy  out  1  high whenever the state is not IDLE.
- node_done  out  1  one-cycle pulse when last_ID reaches ALL_FEATURE.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal cursor cur_id = 0.
- States: IDLE, PLAN, ISSUE, WAIT, UPDATE.
- IDLE:
  - start -> PLAN; cur_id and last_ID cleared to 0.
- PLAN (1 cycle):
  - rem = ALL_FEATURE - cur_id, computed at ID_W+1 bits.
  - n_core = min(ALL_CORE, ceil(rem/32)), 7-bit count. Ceil is (rem+31)>>5, not shift-then-add.
  - Core counter k = 0. Go to ISSUE.
- ISSUE:
  - asg_valid = 1.
  - asg_core = k; asg_base = cur_id + (k<<5).
  - asg_len = 32, except the final chunk when rem is not a multiple of 32: then rem[4:0].
  - asg_last = (k == n_core-1).
  - Payload holds stable while asg_valid && !asg_ready.
  - On handshake: k++. If asg_last, go to WAIT.
  - Back-to-back handshakes allowed: one chunk per cycle.
- WAIT:
  - Hold until round_done, then go to UPDATE.
  - round_done outside WAIT is ignored.
- UPDATE (1 cycle):
  - cur_id = min(cur_id + (n_core<<5), ALL_FEATURE); last_ID = the new cur_id; last_valid pulses.
  - If cur_id == ALL_FEATURE: node_done pulses, go to IDLE. Otherwise go to PLAN.
- Latency: start to first asg_valid = 2 cycles; round_done to the next round's asg_valid = 3 cycles.
- Boundary conditions:
  - rem exactly a multiple of 32: final chunk length 32, never 0.
  - rem >= ALL_CORE*32: full round of ALL_CORE chunks.
  - start while busy: ignored.
  - rst mid-round: immediate return to IDLE, asg_valid drops the next cycle, counters cleared.
  - round_done coincident with the final handshake: ignored, because the state is not yet WAIT.
- With the defaults, the node takes 2 rounds:
  - Round 0: 64 chunks, last_ID = 2048.
  - Round 1: 52 chunks, the last one asg_len = 23, last_ID = 3703.

Optional Feature:
- Macro S1_STALL_CNT_EN.
- When defined:
  - Adds output stall_cycles (16 bits, saturating).
  - Counts cycles in ISSUE with asg_valid && !asg_ready, plus cycles in WAIT.
  - Cleared on rst and on start.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package gnn_sched_pkg holds:
  - constants ALL_FEATURE, ALL_CORE, CHUNK_LOG2;
  - the state enum;
  - an assignment struct {core, base, len, last}.
- S2_calculation must import the same package so both stages agree on the constants.
- One natural sub-module, s1_round_planner: combinational. Takes cur_id and produces rem, n_core and tail_len.

Test Plan:
- Default params, start, asg_ready tied 1, round_done 5 cycles after each asg_last. Required response:
  - 64+52 handshakes.
  - last_ID pulses 2048 then 3703; node_done once.
  - Final asg_len = 23, asg_core = 51.
- ALL_FEATURE=2048. Required response: single round of 64 chunks, all asg_len=32; last_ID=2048; node_done.
- ALL_FEATURE=40. Required response: 2 chunks (len 32, len 8), asg_last on core 1, last_ID=40.
- Random asg_ready backpressure at 50%. Required response:
  - Payload stable while stalled.
  - No lost or duplicated core index.
  - The sum of asg_len equals 3703.
- rst asserted during round 0 at k=30, then start again. Required response: restart from asg_base=0, core 0.
- start pulsed during WAIT, and round_done pulsed during ISSUE. Required response: both ignored; sequence identical to the first scenario.
